exec_ctrl: RTL and testbench

Three-state fetch/read/execute controller with an integrated ALU. It sits directly in front of and behind the 16×16 register file.
- It accepts one 16-bit CR16-style instruction per handshake and drives the register file's two read addresses.
- One cycle later it consumes the two registered read-data words, computes the result, and drives the write-back port (write address, data, write strobe).
- It also maintains the processor status flags.

---
 rtl/exec_pkg.sv | 51 +++++
 rtl/exec_alu.sv | 56 +++++
 rtl/exec_ctrl.sv | 120 ++++++++++++
 tb/tb_exec_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the exec_ctrl fetch/read/execute controller and its ALU.
// CMP/CMPI decode depends on the EXEC_FLAGS_EN build option.
package exec_pkg;

  localparam logic [3:0] OPC_REG  = 4'h0;
  localparam logic [3:0] EXT_NOP  = 4'h0;
  localparam logic [3:0] CODE_AND = 4'h1;
  localparam logic [3:0] CODE_OR  = 4'h2;
  localparam logic [3:0] CODE_XOR = 4'h3;
  localparam logic [3:0] CODE_ADD = 4'h5;
  localparam logic [3:0] CODE_SUB = 4'h9;
  localparam logic [3:0] CODE_CMP = 4'hB;
  localparam logic [3:0] CODE_MOV = 4'hD;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_CMP, OP_ILL
  } alu_op_t;

  // The same 4-bit code selects the op as a register opext or an immediate opcode.
  function automatic alu_op_t code_to_op(input logic [3:0] code);
    alu_op_t op;
    case (code)
      CODE_ADD: op = OP_ADD;
      CODE_SUB: op = OP_SUB;
      CODE_AND: op = OP_AND;
      CODE_OR:  op = OP_OR;
      CODE_XOR: op = OP_XOR;
      CODE_MOV: op = OP_MOV;
`ifdef EXEC_FLAGS_EN
      CODE_CMP: op = OP_CMP;
`else
      CODE_CMP: op = OP_NOP;
`endif
      default:  op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_ctrl: result, write enable and raw flag candidates.
import exec_pkg::*;

module exec_alu #(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              f,
  output logic              z,
  output logic              n,
  output logic              l,
  output logic              write_en
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Bit DATA_W of the 17-bit difference is the unsigned borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign z      = (a == b);
  assign l      = (a < b);
  assign n      = ($signed(a) < $signed(b));

  always_comb begin
    result   = '0;
    c        = 1'b0;
    f        = 1'b0;
    write_en = 1'b0;
    case (op)
      OP_ADD: begin
        result   = w_sum[DATA_W-1:0];
        c        = w_sum[DATA_W];
        f        = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
        write_en = 1'b1;
      end
      OP_SUB: begin
        result   = w_diff[DATA_W-1:0];
        c        = w_diff[DATA_W];
        f        = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);
        write_en = 1'b1;
      end
      OP_CMP: result = w_diff[DATA_W-1:0];
      OP_AND: begin result = a & b; write_en = 1'b1; end
      OP_OR:  begin result = a | b; write_en = 1'b1; end
      OP_XOR: begin result = a ^ b; write_en = 1'b1; end
      OP_MOV: begin result = b;     write_en = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Fetch/read/execute controller in front of and behind a 16x16 register file.
// Build option EXEC_FLAGS_EN adds the {F,L,N,Z,C} status register and CMP/CMPI.
import exec_pkg::*;

module exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] rf_a,
  output logic [DATA_W-1:0] rf_b,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rf_c,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        flags,
  output logic              done,
  output logic              illegal
);

  localparam int RIDX_W = $clog2(NREGS);

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;

  alu_op_t           w_op;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;
  logic              w_c, w_f, w_z, w_n, w_l, w_we;
  logic              w_exec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: if (instr_valid) begin
          r_ir    <= instr;
          r_state <= ST_READ;
        end
        ST_READ:  r_state <= ST_EXEC;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  // Immediate forms reuse the register-op code in the opcode field; the logical ones zero-extend.
  always_comb begin
    w_op = OP_ILL;
    w_b  = rf_rdata2;
    if (r_ir[15:12] == OPC_REG) begin
      w_op = (r_ir[7:4] == EXT_NOP) ? OP_NOP : code_to_op(r_ir[7:4]);
    end else begin
      w_op = code_to_op(r_ir[15:12]);
      if (r_ir[15:12] == CODE_AND || r_ir[15:12] == CODE_OR || r_ir[15:12] == CODE_XOR)
        w_b = {{(DATA_W-8){1'b0}}, r_ir[7:0]};
      else
        w_b = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    end
  end

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (w_op),
    .a        (rf_rdata1),
    .b        (w_b),
    .result   (w_result),
    .c        (w_c),
    .f        (w_f),
    .z        (w_z),
    .n        (w_n),
    .l        (w_l),
    .write_en (w_we)
  );

  assign w_exec      = (r_state == ST_EXEC);
  assign instr_ready = (r_state == ST_FETCH);
  assign done        = w_exec;
  assign illegal     = w_exec && (w_op == OP_ILL);
  assign rf_write    = w_exec && w_we;
  assign rf_wdata    = w_result;
  assign rf_a        = {{(DATA_W-RIDX_W){1'b0}}, r_ir[8 +: RIDX_W]};
  assign rf_b        = {{(DATA_W-RIDX_W){1'b0}}, r_ir[0 +: RIDX_W]};
  assign rf_c        = rf_a;

`ifdef EXEC_FLAGS_EN
  logic [4:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_exec) begin
      case (w_op)
        OP_ADD, OP_SUB: begin
          r_flags[FLAG_C] <= w_c;
          r_flags[FLAG_F] <= w_f;
        end
        OP_CMP: begin
          r_flags[FLAG_Z] <= w_z;
          r_flags[FLAG_L] <= w_l;
          r_flags[FLAG_N] <= w_n;
        end
        default: ;
      endcase
    end
  end

  assign flags = r_flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = &{1'b0, w_c, w_f, w_z, w_n, w_l};
  assign flags          = '0;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl with a register-file model and an instruction-level reference model.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] rf_a, rf_b, rf_c, rf_wdata;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        rf_write, done, illegal;
  logic [4:0]  flags;

  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'h0;
  logic [15:0] pl_data = 16'h0;
  logic [15:0] rf [16];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  exec_ctrl #(.DATA_W(16), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_a(rf_a), .rf_b(rf_b),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_c(rf_c),
    .rf_write(rf_write), .rf_wdata(rf_wdata), .flags(flags),
    .done(done), .illegal(illegal)
  );

  // Register file: registered read, write on strobe, bench preload port when idle.
  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_a[3:0]];
    rf_rdata2 <= rf[rf_b[3:0]];
    if (rf_write) rf[rf_c[3:0]] <= rf_wdata;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  function automatic logic [4:0] fl_exp(input logic [4:0] x);
`ifdef EXEC_FLAGS_EN
    return x;
`else
    return 5'd0 & x;
`endif
  endfunction

  // Instruction-level reference: operand selection and flags from plain integer arithmetic.
  task automatic model(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] rb,
                       input logic [4:0] fi, output logic w, output logic [15:0] wd,
                       output logic ill, output logic [4:0] fo);
    logic [3:0]  opc, code;
    logic [15:0] opnd;
    int ua, ub, sa, sb, r, s;
    opc = ins[15:12]; fo = fi; w = 1'b0; wd = 16'h0; ill = 1'b0;
    if (opc == 4'h0) begin code = ins[7:4]; opnd = rb; end
    else begin
      code = opc;
      if (code == 4'h1 || code == 4'h2 || code == 4'h3) opnd = {8'h00, ins[7:0]};
      else opnd = {{8{ins[7]}}, ins[7:0]};
    end
    ua = int'(a); ub = int'(opnd);
    sa = int'($signed(a)); sb = int'($signed(opnd));
    if (!(opc == 4'h0 && code == 4'h0)) begin
      case (code)
        4'h5: begin r = ua + ub; s = sa + sb; w = 1'b1; wd = r[15:0];
                    fo[0] = (r > 65535); fo[4] = (s > 32767) || (s < -32768); end
        4'h9: begin r = ua - ub; s = sa - sb; w = 1'b1; wd = r[15:0];
                    fo[0] = (ua < ub); fo[4] = (s > 32767) || (s < -32768); end
        4'h1: begin w = 1'b1; wd = a & opnd; end
        4'h2: begin w = 1'b1; wd = a | opnd; end
        4'h3: begin w = 1'b1; wd = a ^ opnd; end
        4'hD: begin w = 1'b1; wd = opnd; end
        4'hB: begin fo[1] = (ua == ub); fo[3] = (ua < ub); fo[2] = (sa < sb); end
        default: ill = 1'b1;
      endcase
    end
    fo = fl_exp(fo);
  endtask

  // One instruction through FETCH/READ/EXEC with checks at every state.
  task automatic run(input logic [15:0] ins, input logic ew, input logic [15:0] ewd,
                     input logic eill, input logic [4:0] efl, input string nm);
    @(negedge clk);
    chk({nm, ".ready"}, 16'(instr_ready), 16'd1);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".rd_ready"}, 16'(instr_ready), 16'd0);
    chk({nm, ".rd_write"}, 16'(rf_write), 16'd0);
    chk({nm, ".rd_done"}, 16'(done), 16'd0);
    chk({nm, ".rf_a"}, rf_a, {12'h0, ins[11:8]});
    chk({nm, ".rf_b"}, rf_b, {12'h0, ins[3:0]});
    @(negedge clk);
    chk({nm, ".done"}, 16'(done), 16'd1);
    chk({nm, ".write"}, 16'(rf_write), 16'(ew));
    chk({nm, ".illegal"}, 16'(illegal), 16'(eill));
    chk({nm, ".rf_c"}, rf_c, {12'h0, ins[11:8]});
    if (ew) chk({nm, ".wdata"}, rf_wdata, ewd);
    @(negedge clk);
    chk({nm, ".post_done"}, 16'(done), 16'd0);
    chk({nm, ".post_ready"}, 16'(instr_ready), 16'd1);
    chk({nm, ".flags"}, 16'(flags), 16'(efl));
    if (ew) chk({nm, ".rf_mem"}, rf[ins[11:8]], ewd);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] rd_v;
    logic [15:0] rs_v;
    logic        ew;
    logic [15:0] wd;
    logic        ill;
    logic [4:0]  fl;
  } vec_t;

  vec_t tbl[15];
  logic [15:0] mregs [16];
  logic [4:0]  mflags;

  initial begin
    logic w, il;
    logic [15:0] wd, ins;
    logic [4:0] fo;
    logic [15:0] seq [4];
    int acc;

    // {instr, Rdest value, Rsrc value, write, wdata, illegal, flags {F,L,N,Z,C}}
    tbl[0]  = '{16'h5105, 16'h0003, 16'h0000, 1'b1, 16'h0008, 1'b0, 5'b00000};
    tbl[1]  = '{16'h0253, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 5'b00001};
    tbl[2]  = '{16'h04B5, 16'h0002, 16'h0007, 1'b0, 16'h0000, 1'b0, 5'b01100};
    tbl[3]  = '{16'hF000, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 5'b00000};
    tbl[4]  = '{16'h0697, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 5'b10000};
    tbl[5]  = '{16'h9101, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 5'b00001};
    tbl[6]  = '{16'h12F0, 16'h1234, 16'h0000, 1'b1, 16'h0030, 1'b0, 5'b00000};
    tbl[7]  = '{16'h2380, 16'h0001, 16'h0000, 1'b1, 16'h0081, 1'b0, 5'b00000};
    tbl[8]  = '{16'h0435, 16'hFF00, 16'h0FF0, 1'b1, 16'hF0F0, 1'b0, 5'b00000};
    tbl[9]  = '{16'hD580, 16'h1111, 16'h0000, 1'b1, 16'hFF80, 1'b0, 5'b00000};
    tbl[10] = '{16'h06D7, 16'h0000, 16'hABCD, 1'b1, 16'hABCD, 1'b0, 5'b00000};
    tbl[11] = '{16'h0000, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 5'b00000};
    tbl[12] = '{16'h0047, 16'h0001, 16'h0002, 1'b0, 16'h0000, 1'b1, 5'b00000};
    tbl[13] = '{16'hB8FF, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 5'b00010};
    tbl[14] = '{16'h0152, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 5'b10000};

    do_reset();
    @(negedge clk);
    chk("rst.ready", 16'(instr_ready), 16'd1);
    chk("rst.write", 16'(rf_write), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.illegal", 16'(illegal), 16'd0);
    chk("rst.rf_a", rf_a, 16'h0);
    chk("rst.rf_b", rf_b, 16'h0);
    chk("rst.rf_c", rf_c, 16'h0);
    chk("rst.wdata", rf_wdata, 16'h0);
    chk("rst.flags", 16'(flags), 16'h0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      preload(tbl[i].ins[3:0], tbl[i].rs_v);
      preload(tbl[i].ins[11:8], tbl[i].rd_v);
      run(tbl[i].ins, tbl[i].ew, tbl[i].wd, tbl[i].ill, fl_exp(tbl[i].fl), $sformatf("vec%0d", i));
    end

    // Held instr_valid: ready 1,0,0 and writes on edges 2,5,8,11 after first acceptance.
    do_reset();
    for (int k = 1; k <= 4; k++) preload(4'(k), 16'h0100);
    seq[0] = 16'h5101; seq[1] = 16'h5202; seq[2] = 16'h5303; seq[3] = 16'h5404;
    @(negedge clk);
    instr = seq[0]; instr_valid = 1'b1; acc = 0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("tput.ready%0d", k), 16'(instr_ready), 16'((k % 3) == 0));
      chk($sformatf("tput.write%0d", k), 16'(rf_write), 16'((k % 3) == 2));
      if ((k % 3) == 2) chk($sformatf("tput.rf_c%0d", k), rf_c, 16'((k / 3) + 1));
      @(posedge clk); #1;
      if ((k % 3) == 0) begin
        acc++;
        if (acc < 4) instr = seq[acc]; else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) chk($sformatf("tput.reg%0d", k), rf[k], 16'(16'h0100 + k));

    // Reset during READ aborts the instruction.
    do_reset();
    preload(4'h2, 16'hFFFF); preload(4'h3, 16'h0001);
    run(16'h0253, 1'b1, 16'h0000, 1'b0, fl_exp(5'b00001), "pre_rr");
    preload(4'h1, 16'h0003);
    @(negedge clk); instr = 16'h5105; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rr.ready", 16'(instr_ready), 16'd1);
    chk("rr.write", 16'(rf_write), 16'd0);
    chk("rr.done", 16'(done), 16'd0);
    chk("rr.flags", 16'(flags), 16'd0);
    @(negedge clk);
    chk("rr.write2", 16'(rf_write), 16'd0);
    chk("rr.reg1", rf[1], 16'h0003);

    // Reset on the EXEC edge: write still lands, flags clear.
    preload(4'h2, 16'hFFFF);
    run(16'h0253, 1'b1, 16'h0000, 1'b0, fl_exp(5'b00001), "pre_re");
    preload(4'h2, 16'hFFFF);
    @(negedge clk); instr = 16'h0253; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("re.write", 16'(rf_write), 16'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("re.reg2", rf[2], 16'h0000);
    chk("re.flags", 16'(flags), 16'd0);
    chk("re.ready", 16'(instr_ready), 16'd1);

    // Randomized instruction stream against the reference model.
    do_reset();
    mflags = 5'd0;
    for (int r = 0; r < 16; r++) begin
      mregs[r] = 16'($urandom);
      preload(4'(r), mregs[r]);
    end
    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins[15:12] = 4'h0;
      model(ins, mregs[ins[11:8]], mregs[ins[3:0]], mflags, w, wd, il, fo);
      run(ins, w, wd, il, fo, $sformatf("rand%0d", i));
      if (w) mregs[ins[11:8]] = wd;
      mflags = fo;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
